regfile_exec_stage: RTL

REGFILE_EXEC_STAGE -- requirements
Module: regfile_exec_stage

---
 rtl/regfile_exec_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/regfile_exec_stage.sv
// Register-file execute stage: single-cycle ALU with writeback forwarding
// plus a shift-add multiplier that holds off issue while it iterates.
module regfile_exec_stage #(
  parameter int data_width  = 8,
  parameter int adder_width = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [adder_width-1:0] src0,
  input  logic [adder_width-1:0] src1,
  input  logic [adder_width-1:0] dst,
  output logic [adder_width-1:0] rf_r_adder0,
  output logic [adder_width-1:0] rf_r_adder1,
  input  logic [data_width-1:0]  rf_r_data0,
  input  logic [data_width-1:0]  rf_r_data1,
  output logic                   rf_we,
  output logic [adder_width-1:0] rf_w_adder,
  output logic [data_width-1:0]  rf_w_data,
  output logic                   out_valid,
  output logic [data_width-1:0]  out_data,
  output logic                   out_carry,
  output logic                   out_zero,
  output logic [15:0]            retire_count
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam int CNT_W = $clog2(data_width) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(data_width - 1);

  typedef enum logic {S_EXEC = 1'b0, S_MUL = 1'b1} state_t;

  state_t                    r_state, w_next_state;
  logic                      r_we;
  logic [adder_width-1:0]    r_w_adder;
  logic [data_width-1:0]     r_w_data;
  logic                      r_carry;
  logic                      r_zero;
  logic [15:0]               r_retire;
  logic [CNT_W-1:0]          r_cnt;
  logic [2*data_width-1:0]   r_prod;
  logic [2*data_width-1:0]   r_mcand;
  logic [data_width-1:0]     r_mplier;
  logic [adder_width-1:0]    r_mul_dst;

  logic                      w_accept;
  logic                      w_mul_last;
  logic [data_width-1:0]     w_op0, w_op1;
  logic [data_width:0]       w_alu;
  logic [2*data_width-1:0]   w_prod_next;

  // Result in the low bits, carry/borrow in the top bit.
  function automatic logic [data_width:0] alu(input logic [2:0] f_op,
                                               input logic [data_width-1:0] a,
                                               input logic [data_width-1:0] b);
    logic [data_width:0] y;
    case (f_op)
      OP_ADD:  y = {1'b0, a} + {1'b0, b};
      OP_SUB:  y = {1'b0, a} - {1'b0, b};
      OP_AND:  y = {1'b0, a & b};
      OP_OR:   y = {1'b0, a | b};
      OP_XOR:  y = {1'b0, a ^ b};
      OP_SHL1: y = {a, 1'b0};
      default: y = {1'b0, a};
    endcase
    return y;
  endfunction

  assign rf_r_adder0 = src0;
  assign rf_r_adder1 = src1;

  // The result being written this cycle is not yet visible in the register file.
  assign w_op0 = (r_we && (r_w_adder == src0)) ? r_w_data : rf_r_data0;
  assign w_op1 = (r_we && (r_w_adder == src1)) ? r_w_data : rf_r_data1;

  assign w_accept    = in_valid && in_ready;
  assign w_alu       = alu(op, w_op0, w_op1);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EXEC;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EXEC:  if (w_accept && (op == OP_MUL)) w_next_state = S_MUL;
      S_MUL:   if (w_mul_last) w_next_state = S_EXEC;
      default: w_next_state = S_EXEC;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_EXEC:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_w_adder <= '0;
      r_w_data  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_retire  <= '0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_mul_dst <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_MUL) begin
        r_prod   <= w_prod_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_mul_last) begin
          r_we      <= 1'b1;
          r_w_adder <= r_mul_dst;
          r_w_data  <= w_prod_next[data_width-1:0];
          r_carry   <= |w_prod_next[2*data_width-1:data_width];
          r_zero    <= (w_prod_next[data_width-1:0] == '0);
        end
      end else if (w_accept) begin
        if (op == OP_MUL) begin
          r_prod    <= '0;
          r_mcand   <= {{data_width{1'b0}}, w_op0};
          r_mplier  <= w_op1;
          r_cnt     <= '0;
          r_mul_dst <= dst;
        end else begin
          r_we      <= 1'b1;
          r_w_adder <= dst;
          r_w_data  <= w_alu[data_width-1:0];
          r_carry   <= w_alu[data_width];
          r_zero    <= (w_alu[data_width-1:0] == '0);
        end
      end
      if (r_we) r_retire <= r_retire + 16'd1;
    end
  end

  assign rf_we        = r_we;
  assign out_valid    = r_we;
  assign rf_w_adder   = r_w_adder;
  assign rf_w_data    = r_w_data;
  assign out_data     = r_w_data;
  assign out_carry    = r_carry;
  assign out_zero     = r_zero;
  assign retire_count = r_retire;

endmodule
